ap_ctrl_chain_master: RTL and testbench
=======================================

Name: ap_ctrl_chain_master

Overview:
- Initiator side of the ap_ctrl_chain register-access protocol. It turns host read/write requests (valid/ready) into ap_start/ap_continue handshakes toward a DUFT ap_ctrl_chain target.
- It captures ap_return for reads and returns one response per request (valid/ready).
- Single outstanding transaction. Sits between the test host/sequencer and the DUFT wrapper.

Parameters:
- TIMEOUT_CYCLES, 1024, watchdog limit in cycles; used only when AP_MASTER_TIMEOUT_EN is defined.
- ERR_DATA, 32'hDEADBEEF, value returned on rsp_data for a timed-out transaction.

Ports:
- clk  in  1  clock
- ap_rst  in  1  reset: synchronous, active-high; shared with the target
- req_valid  in  1  host request valid
- req_ready  out  1  request accepted when req_valid && req_ready
- req_rd_wr  in  1  1 = read, 0 = write
- req_addr  in  32  target register address
- req_wdata  in  32  write data
- rsp_valid  out  1  response valid
- rsp_ready  in  1  host accepts response
- rsp_data  out  32  read data (0 for writes)
- rsp_rd_wr  out  1  echo of the request type
- rsp_err  out  1  timeout flag (constant 0 when the feature is off)
- addr  out  32  to target
- wr_data  out  32  to target
- rd_wr  out  1  to target
- ap_start  out  1  to target
- ap_continue  out  1  to target
- ap_idle  in  1  from target
- ap_ready  in  1  from target
- ap_done  in  1  from target
- ap_return  in  32  from target, combinational read data

Behaviour:
- Reset (sync, ap_rst=1 at posedge): state M_IDLE; all outputs 0 (req_ready, rsp_valid, rsp_data, rsp_rd_wr, rsp_err, addr, wr_data, rd_wr, ap_start, ap_continue).
  - A reset mid-transaction aborts it; no response is produced.
- req_ready = (state==M_IDLE) && !rsp_valid && ap_idle && !ap_rst.
- M_IDLE: on request handshake, latch addr/wr_data/rd_wr from the req_* inputs, then go to M_START.
- M_START: ap_start=1; addr, wr_data and rd_wr stay stable.
  - Sampled ap_ready && ap_done: capture, go to M_CONT.
  - Sampled ap_ready && !ap_done: go to M_WAIT_DONE.
  - Otherwise stay.
  - ap_start drops on the edge that samples ap_ready.
- M_WAIT_DONE: ap_start=0; on sampled ap_done, capture and go to M_CONT.
- Capture:
  - rsp_data <= rd_wr ? ap_return : 0.
  - rsp_rd_wr <= rd_wr; rsp_err <= 0; rsp_valid <= 1.
- M_CONT: ap_continue=1. On sampled ap_done==0, go to M_IDLE (ap_continue then drops).
  - ap_continue may therefore stay high one cycle after the target reaches idle; this is harmless.
- rsp_valid clears on the edge where rsp_valid && rsp_ready. The response register holds its value otherwise.
- The next request is not accepted until the prior response has drained. A simultaneous drain and new req_valid in M_IDLE is accepted the following cycle.
- Nominal latency, request handshake edge to rsp_valid high:
  - Read: 3 cycles.
  - Write: 4 cycles (the target adds a write-ack cycle).
- Back-to-back throughput: one transaction per 5 cycles for reads, 6 for writes, given rsp_ready=1.
- ap_start is never high while in M_CONT or M_IDLE, so the target cannot re-trigger.

Optional Feature:
- AP_MASTER_TIMEOUT_EN defined:
  - A 32-bit counter clears on entry to M_START and counts in M_START and M_WAIT_DONE.
  - When it reaches TIMEOUT_CYCLES: ap_start<=0, rsp_data<=ERR_DATA, rsp_err<=1, rsp_valid<=1, state<=M_IDLE, and no ap_continue is issued.
  - If ap_done and expiry coincide in the same cycle, ap_done wins and a normal capture occurs.
- Not defined: no counter; rsp_err tied 0; the block waits forever.

Decomposition:
- Package ap_chain_pkg: state encoding localparams M_IDLE=0, M_START=1, M_WAIT_DONE=2, M_CONT=3; the ERR_DATA default; and the RD=1 / WR=0 encoding.
- One sub-module, ap_watchdog: counter with clear/enable/expire outputs, instantiated only under AP_MASTER_TIMEOUT_EN.

Test Plan:
- Reset, then read addr 0x10, with the target returning 0x0000_00AB → ap_start high 1 cycle after accept; rsp_valid after 3 cycles with rsp_data=0xAB, rsp_rd_wr=1; ap_continue high until ap_done=0.
- Write addr 0x20, data 0x1234_5678 → wr_data stable while ap_start=1; rsp_valid 4 cycles after accept; rsp_data=0.
- Hold rsp_ready=0 for 10 cycles after a read → rsp_valid and rsp_data held; req_ready=0 throughout; next request accepted the cycle after the drain.
- Assert ap_rst while in M_START → next cycle all outputs 0, state M_IDLE, no rsp_valid.
- Target model raises ap_ready 2 cycles before ap_done → ap_start drops after ap_ready; capture on ap_done; single response.
- With AP_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=8, target never responds → rsp_err=1, rsp_data=0xDEADBEEF, rsp_valid set 8 cycles after entering M_START; ap_start=0.

Source files
------------

// File: rtl/ap_chain_pkg.sv
// Shared encodings for the ap_ctrl_chain initiator: FSM states, request type and timeout read data.
package ap_chain_pkg;

    typedef enum logic [1:0] {
        M_IDLE      = 2'd0,
        M_START     = 2'd1,
        M_WAIT_DONE = 2'd2,
        M_CONT      = 2'd3
    } state_t;

    localparam logic [31:0] AP_ERR_DATA = 32'hDEADBEEF;

    localparam logic RD = 1'b1;
    localparam logic WR = 1'b0;

endpackage

// File: rtl/ap_watchdog.sv
// Cycle counter that flags expiry on the cycle it would reach LIMIT; clear wins over enable.
// Expiry is combinational from the count so the caller acts on the same edge; no backpressure.
module ap_watchdog #(
    parameter int unsigned LIMIT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [31:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    assign expired = en && !clr && (cnt_q == 32'(LIMIT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ap_ctrl_chain_master.sv
// ap_ctrl_chain initiator: one host request -> ap_start/ap_continue handshake -> one response (AP_MASTER_TIMEOUT_EN adds a watchdog).
// Single outstanding transaction; req_ready stays low until the previous response drains via rsp_ready.
module ap_ctrl_chain_master
    import ap_chain_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] ERR_DATA       = AP_ERR_DATA
) (
    input  logic        clk,
    input  logic        ap_rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_rd_wr,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_rd_wr,
    output logic        rsp_err,
    output logic [31:0] addr,
    output logic [31:0] wr_data,
    output logic        rd_wr,
    output logic        ap_start,
    output logic        ap_continue,
    input  logic        ap_idle,
    input  logic        ap_ready,
    input  logic        ap_done,
    input  logic [31:0] ap_return
);

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wr_data_q, wr_data_d;
    logic        rd_wr_q, rd_wr_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic        rsp_rd_wr_q, rsp_rd_wr_d;
    logic        rsp_err_q, rsp_err_d;
    logic        req_fire, wd_en, wd_expired;
    logic        do_capture, do_timeout;

    assign req_ready = (state_q == M_IDLE) && !rsp_valid_q && ap_idle && !ap_rst;
    assign req_fire  = req_valid && req_ready;
    assign wd_en     = (state_q == M_START) || (state_q == M_WAIT_DONE);

`ifdef AP_MASTER_TIMEOUT_EN
    ap_watchdog #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .rst    (ap_rst),
        .clr    (req_fire),
        .en     (wd_en),
        .expired(wd_expired)
    );
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^{TIMEOUT_CYCLES, wd_en};
    assign wd_expired         = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wr_data_d   = wr_data_q;
        rd_wr_d     = rd_wr_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_rd_wr_d = rsp_rd_wr_q;
        rsp_err_d   = rsp_err_q;
        do_capture  = 1'b0;
        do_timeout  = 1'b0;

        if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end

        case (state_q)
            M_IDLE: begin
                if (req_fire) begin
                    addr_d    = req_addr;
                    wr_data_d = req_wdata;
                    rd_wr_d   = req_rd_wr;
                    state_d   = M_START;
                end
            end
            M_START: begin
                if (ap_ready && ap_done) begin
                    do_capture = 1'b1;
                    state_d    = M_CONT;
                end else if (ap_ready) begin
                    state_d = M_WAIT_DONE;
                end else if (wd_expired) begin
                    do_timeout = 1'b1;
                    state_d    = M_IDLE;
                end
            end
            M_WAIT_DONE: begin
                // A done arriving on the expiry cycle still completes normally.
                if (ap_done) begin
                    do_capture = 1'b1;
                    state_d    = M_CONT;
                end else if (wd_expired) begin
                    do_timeout = 1'b1;
                    state_d    = M_IDLE;
                end
            end
            M_CONT: begin
                if (!ap_done) begin
                    state_d = M_IDLE;
                end
            end
            default: state_d = M_IDLE;
        endcase

        if (do_capture) begin
            rsp_data_d  = (rd_wr_q == RD) ? ap_return : '0;
            rsp_rd_wr_d = rd_wr_q;
            rsp_err_d   = 1'b0;
            rsp_valid_d = 1'b1;
        end
        if (do_timeout) begin
            rsp_data_d  = ERR_DATA;
            rsp_rd_wr_d = rd_wr_q;
            rsp_err_d   = 1'b1;
            rsp_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (ap_rst) begin
            state_q     <= M_IDLE;
            addr_q      <= '0;
            wr_data_q   <= '0;
            rd_wr_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_rd_wr_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wr_data_q   <= wr_data_d;
            rd_wr_q     <= rd_wr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_rd_wr_q <= rsp_rd_wr_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Strobes decode straight from state so start can never overlap continue.
    assign ap_start    = (state_q == M_START);
    assign ap_continue = (state_q == M_CONT);
    assign addr        = addr_q;
    assign wr_data     = wr_data_q;
    assign rd_wr       = rd_wr_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_rd_wr   = rsp_rd_wr_q;
    assign rsp_err     = rsp_err_q;

endmodule

// File: tb/tb_ap_ctrl_chain_master.sv
// Bench for ap_ctrl_chain_master: behavioural ap_ctrl_chain target plus directed and random transactions.
// Expected latency/throughput come from target delay: rsp seen by host D+3 edges after accept, next accept D+5 after.
module tb_ap_ctrl_chain_master;
    import ap_chain_pkg::*;

    logic        clk = 1'b0;
    logic        ap_rst;
    logic        req_valid, req_ready, req_rd_wr;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_ready, rsp_rd_wr, rsp_err;
    logic [31:0] rsp_data, addr, wr_data, ap_return;
    logic        rd_wr, ap_start, ap_continue, ap_idle, ap_ready, ap_done;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // target model configuration and state
    int          tgt_delay = 0, tgt_lead = 0, tgt_starts = 0;
    logic [31:0] tgt_ret = '0;
    bit          tgt_hang = 0;
    int          t_cnt, t_lead;
    bit          t_busy;
    logic        s_rst, s_start, s_cont, s_rd;
    int          overlap = 0;
    int          prev_acc = 0, prev_period = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ap_ctrl_chain_master #(
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk        (clk),
        .ap_rst     (ap_rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_rd_wr  (req_rd_wr),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_rd_wr  (rsp_rd_wr),
        .rsp_err    (rsp_err),
        .addr       (addr),
        .wr_data    (wr_data),
        .rd_wr      (rd_wr),
        .ap_start   (ap_start),
        .ap_continue(ap_continue),
        .ap_idle    (ap_idle),
        .ap_ready   (ap_ready),
        .ap_done    (ap_done),
        .ap_return  (ap_return)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Registered ap_ctrl_chain target: picks up start when idle, done D updates later, holds done until continue.
    task automatic tgt_step();
        if (t_cnt == 0) begin
            ap_done   = 1'b1;
            t_busy    = 0;
            ap_return = tgt_ret;
            if (t_lead == 0) ap_ready = 1'b1;
        end else if (t_cnt == t_lead) begin
            ap_ready = 1'b1;
        end
    endtask

    initial begin
        ap_idle = 1'b1; ap_ready = 1'b0; ap_done = 1'b0; ap_return = '0;
        t_busy = 0; t_cnt = 0; t_lead = 0;
        forever begin
            @(negedge clk); #1;
            s_rst = ap_rst; s_start = ap_start; s_cont = ap_continue; s_rd = rd_wr;
            @(posedge clk); #1;
            ap_ready = 1'b0;
            if (s_rst) begin
                ap_idle = 1'b1; ap_done = 1'b0; t_busy = 0; ap_return = '0;
            end else if (ap_done) begin
                if (s_cont) begin
                    ap_done = 1'b0;
                    ap_idle = 1'b1;
                end
            end else if (t_busy) begin
                if (!tgt_hang) begin
                    t_cnt--;
                    tgt_step();
                end
            end else if (s_start) begin
                t_busy = 1; ap_idle = 1'b0; tgt_starts++;
                ap_return = ~tgt_ret;
                t_cnt  = tgt_delay + ((s_rd == RD) ? 0 : 1);
                t_lead = tgt_lead;
                if (!tgt_hang) tgt_step();
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (ap_start && ap_continue) overlap++;
        end
    end

    // d: target delay before its write-ack cycle; lead: ap_ready lead over ap_done; hold: cycles rsp_ready stays low
    task automatic do_txn(input logic rd, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] ret, input int d, input int lead, input int hold,
                          input string tag);
        int edges, stab, late, viol, d_eff, acc;
        bit seen_rdy;
        logic [31:0] exp_data;
        d_eff    = d + ((rd == RD) ? 0 : 1);
        exp_data = (rd == RD) ? ret : 32'h0;
        tgt_delay = d; tgt_lead = lead; tgt_ret = ret; tgt_starts = 0;
        @(negedge clk);
        req_valid = 1'b1; req_rd_wr = rd; req_addr = a; req_wdata = wd;
        edges = 0;
        while (!req_ready && edges < 100) begin
            @(negedge clk);
            edges++;
        end
        chk({tag, "_req_ready"}, {31'b0, req_ready}, 32'd1);
        @(posedge clk); #1;
        acc = cyc;
        req_valid = 1'b0; req_rd_wr = ~rd; req_addr = $urandom; req_wdata = $urandom;
        rsp_ready = (hold == 0);
        if (prev_period > 0) chk({tag, "_period"}, acc - prev_acc, prev_period);
        @(negedge clk);
        chk({tag, "_start"}, {31'b0, ap_start}, 32'd1);
        edges = 0; stab = 0; late = 0; seen_rdy = 0;
        while (!rsp_valid && edges < 200) begin
            if (ap_start && (addr !== a || wr_data !== wd || rd_wr !== rd)) stab++;
            if (seen_rdy && ap_start) late++;
            if (ap_ready) seen_rdy = 1;
            @(negedge clk);
            edges++;
        end
        chk({tag, "_latency"}, edges + 1, d_eff + 3);
        chk({tag, "_data"}, rsp_data, exp_data);
        chk({tag, "_rd_wr"}, {31'b0, rsp_rd_wr}, {31'b0, rd});
        chk({tag, "_err"}, {31'b0, rsp_err}, 32'd0);
        chk({tag, "_starts"}, tgt_starts, 1);
        chk({tag, "_stable"}, stab, 0);
        chk({tag, "_start_after_ready"}, late, 0);
        chk({tag, "_cont"}, {30'b0, ap_continue, ap_start}, 32'd2);
        if (hold > 0) begin
            viol = 0;
            repeat (hold) begin
                @(negedge clk);
                if (rsp_valid !== 1'b1 || rsp_data !== exp_data || req_ready !== 1'b0) viol++;
            end
            chk({tag, "_hold"}, viol, 0);
            rsp_ready = 1'b1;
            @(negedge clk);
            chk({tag, "_drained"}, {31'b0, rsp_valid}, 32'd0);
            chk({tag, "_ready_after_drain"}, {31'b0, req_ready}, 32'd1);
        end
        prev_acc    = acc;
        prev_period = (hold == 0) ? d_eff + 5 : 0;
    endtask

    initial begin
        int edges, seen;
        logic rd;
        int d, lead, hold;
        ap_rst = 1'b1; req_valid = 1'b0; req_rd_wr = 1'b0; req_addr = '0; req_wdata = '0;
        rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ctrl", {25'b0, req_ready, rsp_valid, rsp_rd_wr, rsp_err, rd_wr, ap_start, ap_continue}, 32'd0);
        chk("rst_addr", addr, 32'd0);
        chk("rst_wdata", wr_data, 32'd0);
        chk("rst_rdata", rsp_data, 32'd0);
        ap_rst = 1'b0;
        @(negedge clk);
        chk("idle_req_ready", {31'b0, req_ready}, 32'd1);

        do_txn(RD, 32'h10, 32'h0, 32'h0000_00AB, 0, 0, 0, "rd10");
        do_txn(WR, 32'h20, 32'h1234_5678, 32'h5555_AAAA, 0, 0, 0, "wr20");
        do_txn(RD, 32'h44, 32'h0, 32'h0BAD_F00D, 0, 0, 10, "hold");
        do_txn(RD, 32'h30, 32'h0, 32'hCAFE_0001, 2, 2, 0, "lead");

        // reset while the master is driving ap_start
        prev_period = 0;
        tgt_delay = 3; tgt_lead = 0;
        @(negedge clk);
        req_valid = 1'b1; req_rd_wr = RD; req_addr = 32'h60; req_wdata = 32'h0;
        edges = 0;
        while (!req_ready && edges < 100) begin
            @(negedge clk);
            edges++;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("mid_in_start", {31'b0, ap_start}, 32'd1);
        ap_rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_ctrl", {25'b0, req_ready, rsp_valid, rsp_rd_wr, rsp_err, rd_wr, ap_start, ap_continue}, 32'd0);
        chk("mid_rst_addr", addr, 32'd0);
        chk("mid_rst_rdata", rsp_data, 32'd0);
        ap_rst = 1'b0;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        chk("mid_no_rsp", seen, 0);
        chk("mid_ready_again", {31'b0, req_ready}, 32'd1);

        for (int i = 0; i < 40; i++) begin
            rd   = 1'($urandom_range(0, 1));
            d    = $urandom_range(0, 3);
            lead = $urandom_range(0, d + ((rd == RD) ? 0 : 1));
            hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
            do_txn(rd, $urandom, $urandom, $urandom, d, lead, hold, $sformatf("rnd%0d", i));
        end
        chk("no_start_during_cont", overlap, 0);

`ifdef AP_MASTER_TIMEOUT_EN
        prev_period = 0;
        tgt_hang = 1;
        @(negedge clk);
        req_valid = 1'b1; req_rd_wr = RD; req_addr = 32'h50; req_wdata = 32'h0;
        edges = 0;
        while (!req_ready && edges < 100) begin
            @(negedge clk);
            edges++;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        edges = 0;
        while (!rsp_valid && edges < 100) begin
            @(negedge clk);
            edges++;
        end
        chk("to_latency", edges, 8);
        chk("to_err", {31'b0, rsp_err}, 32'd1);
        chk("to_data", rsp_data, 32'hDEAD_BEEF);
        chk("to_strobes", {30'b0, ap_start, ap_continue}, 32'd0);
        @(negedge clk);
        chk("to_no_cont", {31'b0, ap_continue}, 32'd0);
        tgt_hang = 0;
        ap_rst = 1'b1;
        @(negedge clk);
        ap_rst = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
